// File: rtl/v68k_pkg.sv
// Shared encodings for the 68000-style register file write path:
// operand sizes and the long-write sequencer states.
package v68k_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LONG_LO = 1'b1;

    // Sizes that modify a register on a single beat.
    function automatic logic is_single_beat(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_WORD);
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational lane merge: computes the new register value for a byte,
// word (optionally sign-extended) or completed long write.
module lane_merge
    import v68k_pkg::*;
#(
    parameter int width = 16
) (
    input  logic [2*width-1:0] old_val,
    input  logic [width-1:0]   din,
    input  logic [1:0]         size,
    input  logic               sext,
    input  logic [width-1:0]   high,
    input  logic               long_phase,
    output logic [2*width-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        if (long_phase) begin
            // Second long beat: size and sext on the bus are irrelevant.
            new_val = {high, din};
        end else begin
            case (size)
                SZ_BYTE: new_val[7:0] = din[7:0];
                SZ_WORD: begin
                    if (sext)
                        new_val = {{width{din[width-1]}}, din};
                    else
                        new_val = {old_val[2*width-1:width], din};
                end
                default: new_val = old_val;
            endcase
        end
    end

endmodule

// File: rtl/demux8_reg_writer.sv
// Write-side steering into the eight data registers D0-D7, with two-beat
// long-write sequencing, abort and illegal-size error reporting.
module demux8_reg_writer
    import v68k_pkg::*;
#(
    parameter int width = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    input  logic [2:0]           WR_SEL,
    input  logic [1:0]           WR_SIZE,
    input  logic                 WR_SEXT,
    input  logic [width-1:0]     DIN,
    input  logic                 ABORT,
    output logic [2*width-1:0]   R0,
    output logic [2*width-1:0]   R1,
    output logic [2*width-1:0]   R2,
    output logic [2*width-1:0]   R3,
    output logic [2*width-1:0]   R4,
    output logic [2*width-1:0]   R5,
    output logic [2*width-1:0]   R6,
    output logic [2*width-1:0]   R7,
    output logic                 LONG_PEND,
    output logic                 ERR
);

    logic [0:0]         state_reg, state_next;
    logic [width-1:0]   high_reg, high_next;
    logic [2:0]         sel_reg, sel_next;
    logic               err_reg, err_next;
    logic               accept;
    logic               long_phase;
    logic               wr_en;
    logic [2:0]         tgt_sel;
    logic [2*width-1:0] old_val;
    logic [2*width-1:0] merged;
    logic [2*width-1:0] r_reg [8];
    logic [7:0]         wen;

    assign WR_READY   = !ABORT;
    assign accept     = WR_VALID && WR_READY;
    assign long_phase = (state_reg == ST_LONG_LO);
    assign tgt_sel    = long_phase ? sel_reg : WR_SEL;
    assign old_val    = r_reg[tgt_sel];

    always_comb begin
        state_next = state_reg;
        high_next  = high_reg;
        sel_next   = sel_reg;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_single_beat(WR_SIZE)) begin
                        wr_en = 1'b1;
                    end else if (WR_SIZE == SZ_LONG) begin
                        state_next = ST_LONG_LO;
                        high_next  = DIN;
                        sel_next   = WR_SEL;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: begin
                // Abort wins over a beat offered alongside it (WR_READY is low).
                if (ABORT) begin
                    state_next = ST_IDLE;
                    high_next  = '0;
                    sel_next   = '0;
                    err_next   = 1'b1;
                end else if (accept) begin
                    wr_en      = 1'b1;
                    state_next = ST_IDLE;
                    high_next  = '0;
                    sel_next   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= ST_IDLE;
            high_reg  <= '0;
            sel_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            high_reg  <= high_next;
            sel_reg   <= sel_next;
            err_reg   <= err_next;
        end
    end

    lane_merge #(
        .width(width)
    ) u_merge (
        .old_val    (old_val),
        .din        (DIN),
        .size       (WR_SIZE),
        .sext       (WR_SEXT),
        .high       (high_reg),
        .long_phase (long_phase),
        .new_val    (merged)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg
            assign wen[gi] = wr_en && (tgt_sel == 3'(gi));

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N)
                    r_reg[gi] <= '0;
                else if (wen[gi])
                    r_reg[gi] <= merged;
            end
        end
    endgenerate

    assign R0        = r_reg[0];
    assign R1        = r_reg[1];
    assign R2        = r_reg[2];
    assign R3        = r_reg[3];
    assign R4        = r_reg[4];
    assign R5        = r_reg[5];
    assign R6        = r_reg[6];
    assign R7        = r_reg[7];
    assign LONG_PEND = long_phase;
    assign ERR       = err_reg;

endmodule

// File: tb/tb_demux8_reg_writer.sv
// Directed bench for demux8_reg_writer (width 16): merges, sign extension,
// long sequencing, abort, illegal size and asynchronous reset mid-long.
module tb_demux8_reg_writer;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] W = 2'b01;
    localparam logic [1:0] L = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [2:0]  WR_SEL = '0;
    logic [1:0]  WR_SIZE = '0;
    logic        WR_SEXT = 1'b0;
    logic [15:0] DIN = '0;
    logic        ABORT = 1'b0;
    logic [31:0] r [8];
    logic        LONG_PEND;
    logic        ERR;

    int errors = 0;
    int checks = 0;

    demux8_reg_writer #(.width(16)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .WR_VALID  (WR_VALID),
        .WR_READY  (WR_READY),
        .WR_SEL    (WR_SEL),
        .WR_SIZE   (WR_SIZE),
        .WR_SEXT   (WR_SEXT),
        .DIN       (DIN),
        .ABORT     (ABORT),
        .R0        (r[0]),
        .R1        (r[1]),
        .R2        (r[2]),
        .R3        (r[3]),
        .R4        (r[4]),
        .R5        (r[5]),
        .R6        (r[6]),
        .R7        (r[7]),
        .LONG_PEND (LONG_PEND),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One valid beat for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic beat(input logic [2:0] sel, input logic [1:0] size,
                        input logic sext, input logic [15:0] d);
        WR_VALID = 1'b1;
        WR_SEL   = sel;
        WR_SIZE  = size;
        WR_SEXT  = sext;
        DIN      = d;
        step();
        WR_VALID = 1'b0;
        $display("beat sel=%0d size=%0d sext=%0d din=%h -> r[sel]=%h pend=%b err=%b",
                 sel, size, sext, d, r[sel], LONG_PEND, ERR);
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_r%0d got=%h exp=%h", i, r[i], 32'h0);
            end
        end
        checks++;
        if (LONG_PEND !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got pend=%b err=%b exp 0 0", LONG_PEND, ERR);
        end
        ABORT = 1'b1;
        #1;
        checks++;
        if (WR_READY !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got=%b exp=0", WR_READY);
        end
        ABORT = 1'b0;
        #1;
        checks++;
        if (WR_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle got=%b exp=1", WR_READY);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
    endtask

    task automatic test_byte_word();
        beat(3'd3, L, 1'b0, 16'hAABB);
        beat(3'd0, B, 1'b1, 16'hCCDD);
        checks++;
        if (r[3] !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL long_setup_r3 got=%h exp=%h", r[3], 32'hAABBCCDD);
        end
        beat(3'd3, B, 1'b0, 16'h0011);
        checks++;
        if (r[3] !== 32'hAABBCC11) begin
            errors++;
            $display("FAIL byte_merge got=%h exp=%h", r[3], 32'hAABBCC11);
        end
        beat(3'd3, W, 1'b0, 16'h1234);
        checks++;
        if (r[3] !== 32'hAABB1234) begin
            errors++;
            $display("FAIL word_merge got=%h exp=%h", r[3], 32'hAABB1234);
        end
    endtask

    task automatic test_sext();
        beat(3'd5, W, 1'b1, 16'h8001);
        checks++;
        if (r[5] !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL word_sext got=%h exp=%h", r[5], 32'hFFFF8001);
        end
        beat(3'd5, L, 1'b0, 16'h0000);
        beat(3'd5, L, 1'b0, 16'h0000);
        checks++;
        if (r[5] !== 32'h0) begin
            errors++;
            $display("FAIL clear_r5 got=%h exp=%h", r[5], 32'h0);
        end
        beat(3'd5, W, 1'b0, 16'h8001);
        checks++;
        if (r[5] !== 32'h00008001) begin
            errors++;
            $display("FAIL word_nosext got=%h exp=%h", r[5], 32'h00008001);
        end
        beat(3'd5, B, 1'b1, 16'h0080);
        checks++;
        if (r[5] !== 32'h00008080) begin
            errors++;
            $display("FAIL byte_ignores_sext got=%h exp=%h", r[5], 32'h00008080);
        end
    endtask

    task automatic test_long();
        int pend_cycles = 0;
        beat(3'd7, L, 1'b0, 16'hDEAD);
        if (LONG_PEND === 1'b1) pend_cycles++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (LONG_PEND === 1'b1) pend_cycles++;
        end
        checks++;
        if (r[7] !== 32'h0) begin
            errors++;
            $display("FAIL long_no_early_write got=%h exp=%h", r[7], 32'h0);
        end
        beat(3'd2, B, 1'b1, 16'hBEEF);
        checks++;
        if (r[7] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL long_r7 got=%h exp=%h", r[7], 32'hDEADBEEF);
        end
        checks++;
        if (r[2] !== 32'h0) begin
            errors++;
            $display("FAIL long_r2_untouched got=%h exp=%h", r[2], 32'h0);
        end
        checks++;
        if (pend_cycles != 4 || LONG_PEND !== 1'b0) begin
            errors++;
            $display("FAIL long_pend got cycles=%0d pend_after=%b exp cycles=4 pend_after=0",
                     pend_cycles, LONG_PEND);
        end
    endtask

    task automatic test_back_to_back();
        beat(3'd4, L, 1'b0, 16'h1111);
        beat(3'd6, L, 1'b0, 16'h2222);
        checks++;
        if (r[4] !== 32'h11112222 || r[6] !== 32'h0 || LONG_PEND !== 1'b0) begin
            errors++;
            $display("FAIL long_as_low got r4=%h r6=%h pend=%b exp r4=11112222 r6=0 pend=0",
                     r[4], r[6], LONG_PEND);
        end
        beat(3'd4, L, 1'b0, 16'h3333);
        checks++;
        if (LONG_PEND !== 1'b1) begin
            errors++;
            $display("FAIL immediate_new_long got pend=%b exp=1", LONG_PEND);
        end
        beat(3'd1, W, 1'b1, 16'h4444);
        checks++;
        if (r[4] !== 32'h33334444 || r[1] !== 32'h0) begin
            errors++;
            $display("FAIL second_long got r4=%h r1=%h exp r4=33334444 r1=0", r[4], r[1]);
        end
    endtask

    task automatic test_abort();
        ABORT = 1'b1;
        step();
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_err got=%b exp=0", ERR);
        end
        ABORT = 1'b0;
        beat(3'd1, L, 1'b0, 16'hCAFE);
        WR_VALID = 1'b1;
        WR_SIZE  = W;
        WR_SEL   = 3'd1;
        DIN      = 16'h5555;
        ABORT    = 1'b1;
        #1;
        checks++;
        if (WR_READY !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got=%b exp=0", WR_READY);
        end
        step();
        ABORT    = 1'b0;
        WR_VALID = 1'b0;
        checks++;
        if (r[1] !== 32'h0 || ERR !== 1'b1 || LONG_PEND !== 1'b0) begin
            errors++;
            $display("FAIL abort_effect got r1=%h err=%b pend=%b exp r1=0 err=1 pend=0",
                     r[1], ERR, LONG_PEND);
        end
        step();
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_one_cycle got=%b exp=0", ERR);
        end
        beat(3'd1, W, 1'b0, 16'h7777);
        checks++;
        if (r[1] !== 32'h00007777) begin
            errors++;
            $display("FAIL after_abort_word got=%h exp=%h", r[1], 32'h00007777);
        end
    endtask

    task automatic test_illegal();
        beat(3'd0, X, 1'b1, 16'hFFFF);
        checks++;
        if (ERR !== 1'b1 || r[0] !== 32'h0 || LONG_PEND !== 1'b0) begin
            errors++;
            $display("FAIL illegal got err=%b r0=%h pend=%b exp err=1 r0=0 pend=0",
                     ERR, r[0], LONG_PEND);
        end
        beat(3'd0, W, 1'b0, 16'hABCD);
        checks++;
        if (ERR !== 1'b0 || r[0] !== 32'h0000ABCD || r[3] !== 32'hAABB1234) begin
            errors++;
            $display("FAIL after_illegal got err=%b r0=%h r3=%h exp err=0 r0=0000abcd r3=aabb1234",
                     ERR, r[0], r[3]);
        end
    endtask

    task automatic test_reset_mid();
        beat(3'd6, L, 1'b0, 16'h9999);
        RESET_N = 1'b0;
        #2;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r[i] !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_r%0d got=%h exp=%h", i, r[i], 32'h0);
            end
        end
        checks++;
        if (LONG_PEND !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pend got=%b exp=0", LONG_PEND);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        beat(3'd6, W, 1'b0, 16'h0001);
        checks++;
        if (r[6] !== 32'h00000001 || LONG_PEND !== 1'b0) begin
            errors++;
            $display("FAIL no_stale_high got r6=%h pend=%b exp r6=00000001 pend=0",
                     r[6], LONG_PEND);
        end
    endtask

    initial begin
        test_reset();
        test_byte_word();
        test_sext();
        test_long();
        test_back_to_back();
        test_abort();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux8_reg_writer.md
# demux8_reg_writer

Write-side counterpart of the 8-way register read multiplexer: accepts writes over a `width`-bit data bus and steers them into one of eight `2*width`-bit data registers (D0–D7). It handles 68000 operand sizes: byte and word writes merge into the low lanes, word writes can be sign-extended, and long writes are sequenced as two bus beats. Its eight register outputs feed the read-side 8:1 multiplexers directly.

## Interface
Parameters:
- `width`, 16, data bus width; each register is `2*width` bits.

Ports:
- `CLK` in 1: single clock, rising-edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `WR_VALID` in 1: write beat offered.
- `WR_READY` out 1: beat accepted when `WR_VALID && WR_READY` at the rising edge.
- `WR_SEL` in 3: target register, 0–7.
- `WR_SIZE` in 2: 00 byte, 01 word, 10 long, 11 illegal.
- `WR_SEXT` in 1: word writes only; sign-extend `DIN[width-1]` into the upper half.
- `DIN` in `width`: write data.
- `ABORT` in 1: cancels a pending long write.
- `R0`–`R7` out `2*width` each: register contents.
- `LONG_PEND` out 1: high while waiting for the second long beat.
- `ERR` out 1: one-cycle pulse on an illegal size or an aborted long write.

## Operation
- States: IDLE, LONG_LO.
- IDLE, accepted beat:
  - Byte: `R[SEL][7:0] <= DIN[7:0]`; other bits unchanged.
  - Word, `WR_SEXT`=0: `R[SEL][width-1:0] <= DIN`; upper half unchanged.
  - Word, `WR_SEXT`=1: `R[SEL] <= {{width{DIN[width-1]}}, DIN}`.
  - Long: latch `DIN` as the high word and latch `WR_SEL`; go to LONG_LO. No register changes.
  - Illegal size (11): no write; `ERR` pulses; stay in IDLE.
- LONG_LO, accepted beat:
  - `R[latched SEL] <= {high, DIN}` written atomically; return to IDLE.
  - `WR_SEL`, `WR_SIZE` and `WR_SEXT` are ignored on this beat.
- `WR_SEXT` is ignored for byte and long writes.
- `ABORT`:
  - In LONG_LO: return to IDLE, discard the high word, no register write, `ERR` pulses.
  - In IDLE: no effect. It has no effect on anything except a pending long write.
- `WR_READY = !ABORT`. A beat offered in the same cycle as `ABORT` is not accepted.

## Timing
- Reset (async assert): all `R0`–`R7` = 0, state IDLE, holding registers = 0, `LONG_PEND`=0, `ERR`=0.
- Reset deassertion is synchronized by the surrounding design. `WR_READY` follows `ABORT` even during reset.
- Write latency: the register updates on the accepting edge and is visible on `R*` the next cycle.
- Throughput: one beat per cycle; a long write occupies exactly two accepted beats. Gaps between the two beats are allowed indefinitely.
- `LONG_PEND` is registered: high the cycle after the first long beat, low the cycle after the second beat or abort.
- `ERR` is registered, high for exactly one cycle after the triggering edge.
- Reset mid-long: the pending high word is lost, no partial write, state IDLE.
- Back-to-back: a long beat in LONG_LO is treated as the low beat, not a new long. A new long may start in the cycle immediately after completion.

## Structure
- Shared package `v68k_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_WORD`, `SZ_LONG`, `SZ_ILL`.
  - State encoding for IDLE/LONG_LO.
- Sub-module `lane_merge`: combinational; inputs old value, `DIN`, size, sext, high word, long-phase flag; output new `2*width` value. Instantiated once and shared, with the result written to the decoded register.
- Top level: decode of `WR_SEL`/latched SEL into eight write enables, the eight registers, the FSM, and `ERR` generation.

## Test plan
- Reset mid-operation: after writes, pulse `RESET_N` low between two long beats → all `R*`=0, `LONG_PEND`=0, and no write from the stale high word.
- Byte and word merge: R3=0xAABBCCDD (width 16), byte write `DIN`=0x0011 → R3=0xAABBCC11. Then word write 0x1234 → R3=0xAABB1234.
- Sign extension: word write to R5 with `DIN`=0x8001 and `WR_SEXT`=1 → R5=0xFFFF8001. The same write with `WR_SEXT`=0 on R5=0 → 0x00008001.
- Long sequencing: long to R7 with 0xDEAD, three idle cycles, second beat 0xBEEF with `WR_SEL`=2 → R7=0xDEADBEEF and R2 unchanged. `LONG_PEND` is high for exactly the gap plus one cycle.
- Abort: first long beat to R1, then `ABORT` together with a valid beat → `WR_READY`=0, no write, `ERR` pulses one cycle, state IDLE. The next word write behaves normally.
- Illegal size: `WR_SIZE`=11 → no register changes and a one-cycle `ERR`. A legal write on the next cycle is accepted.
